// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle RV32 core: byte/half/word RAM with sign/zero-extended loads,
// misalignment detection with a sticky error flag, and an I/O window (display, cycle counter, status).
module dmem_mmio #(
    parameter int          DEPTH      = 64,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00,
    parameter int          HEX_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic                    re,
    input  logic [1:0]              size,
    input  logic                    uns,
    input  logic [31:0]             a,
    input  logic [31:0]             wd,
    output logic [31:0]             rd,
    output logic                    misalign,
    output logic [7*HEX_DIGITS-1:0] hex
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [31:0]   disp;
    logic [31:0]   cyc;
    logic          err;
    logic          is_io;
    logic          bad;
    logic          io_store;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   word;
    logic [7:0]    lbyte;
    logic [15:0]   lhalf;

    assign is_io = (a[31:8] == IO_BASE[31:8]);
    assign idx   = a[AW+1:2];

    always_comb begin
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            2'b10:   bad = (a[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
    end

    assign misalign = (we | re) & bad;
    // Only full-word stores reach the I/O registers; narrower ones are silently dropped.
    assign io_store = we & ~misalign & is_io & (size == 2'b10);

    always_comb begin
        be     = 4'b0000;
        wlanes = wd;
        case (size)
            2'b00: begin
                be     = 4'b0001 << a[1:0];
                wlanes = {4{wd[7:0]}};
            end
            2'b01: begin
                be     = a[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wd[15:0]}};
            end
            2'b10: begin
                be     = 4'b1111;
                wlanes = wd;
            end
            default: begin
                be     = 4'b0000;
                wlanes = wd;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (we && !misalign && !is_io && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    // Later assignments win: a CYC store overrides the increment, and a fault overrides an err clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp <= 32'd0;
            cyc  <= 32'd0;
            err  <= 1'b0;
        end else begin
            cyc <= cyc + 32'd1;
            if (io_store && a[7:2] == 6'd0) disp <= wd;
            if (io_store && a[7:2] == 6'd1) cyc <= wd;
            if (io_store && a[7:2] == 6'd2 && wd[0]) err <= 1'b0;
            if (misalign) err <= 1'b1;
        end
    end

    always_comb begin
        word = mem[idx];
        if (is_io) begin
            case (a[7:2])
                6'd0:    word = disp;
                6'd1:    word = cyc;
                6'd2:    word = {31'd0, err};
                default: word = 32'd0;
            endcase
        end
    end

    always_comb begin
        case (a[1:0])
            2'd0:    lbyte = word[7:0];
            2'd1:    lbyte = word[15:8];
            2'd2:    lbyte = word[23:16];
            default: lbyte = word[31:24];
        endcase
        lhalf = a[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   rd = uns ? {24'd0, lbyte} : {{24{lbyte[7]}}, lbyte};
            2'b01:   rd = uns ? {16'd0, lhalf} : {{16{lhalf[15]}}, lhalf};
            default: rd = word;
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    for (genvar g = 0; g < HEX_DIGITS; g++) begin : g_digit
        assign hex[7*g +: 7] = seg7(disp[4*g +: 4]);
    end
endmodule
